// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port main memory between the instruction
// fetch path and the data path (load/store, push/pop). One access per cycle,
// read data routed back to its owner one cycle after the grant.
// Optional build macro MEM_ARB_RR_EN: contention is resolved round-robin
// instead of fixed data priority with a starvation guard for fetch.
//
// Handshake: a requester raises *_req with its payload and holds both stable
// until it sees *_gnt high in the same cycle (the grant is combinational).
// Dropping *_req before a grant withdraws the request. A granted read returns
// one cycle later as a single-cycle *_rvalid pulse with no backpressure.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state,
  output logic [3:0]        dbg_starve_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_F = 2'd1,
    OWN_D = 2'd2
  } state_e;

  localparam logic SIDE_F = 1'b0;
  localparam logic SIDE_D = 1'b1;
  localparam logic [3:0] STARVE_CNT_MAX = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0] f_hold_q, f_hold_d;
  logic [DATA_W-1:0] d_hold_q, d_hold_d;
`ifdef MEM_ARB_RR_EN
  logic              rr_last_q, rr_last_d;
`endif

  // Grant selection; nothing is granted while reset is held low.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset) begin
      if (f_req && d_req) begin
`ifdef MEM_ARB_RR_EN
        if (rr_last_q == SIDE_F) d_gnt = 1'b1;
        else                     f_gnt = 1'b1;
`else
        if (starve_cnt_q == STARVE_CNT_MAX) f_gnt = 1'b1;
        else                                d_gnt = 1'b1;
`endif
      end else if (f_req) begin
        f_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Memory strobe and payload mux; payload is zero when no side is granted.
  always_comb begin
    mem_en    = f_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_addr = f_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Read return: owner sees live memory data, the other side keeps its last word.
  always_comb begin
    f_rvalid       = rd_pend_q & (rd_owner_q == SIDE_F);
    d_rvalid       = rd_pend_q & (rd_owner_q == SIDE_D);
    f_rdata        = f_rvalid ? mem_rdata : f_hold_q;
    d_rdata        = d_rvalid ? mem_rdata : d_hold_q;
    dbg_state      = state_q;
    dbg_starve_cnt = starve_cnt_q;
  end

  // Next-state: ownership, pending read, starvation count and held read data.
  always_comb begin
    state_d      = IDLE;
    starve_cnt_d = starve_cnt_q;
    rd_pend_d    = 1'b0;
    rd_owner_d   = rd_owner_q;
    f_hold_d     = f_hold_q;
    d_hold_d     = d_hold_q;
    if (f_gnt) begin
      state_d    = OWN_F;
      rd_pend_d  = 1'b1;
      rd_owner_d = SIDE_F;
    end else if (d_gnt) begin
      state_d = OWN_D;
      if (!d_we) begin
        rd_pend_d  = 1'b1;
        rd_owner_d = SIDE_D;
      end
    end
    if (f_rvalid) f_hold_d = mem_rdata;
    if (d_rvalid) d_hold_d = mem_rdata;
`ifdef MEM_ARB_RR_EN
    starve_cnt_d = '0;
`else
    if (f_gnt || !f_req) begin
      starve_cnt_d = '0;
    end else if (d_gnt && (starve_cnt_q != STARVE_CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
`endif
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin pointer remembers which side won the most recent grant.
  always_comb begin
    rr_last_d = rr_last_q;
    if (f_gnt)      rr_last_d = SIDE_F;
    else if (d_gnt) rr_last_d = SIDE_D;
  end
`endif

  // State registers; reset drops any in-flight read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= SIDE_F;
      f_hold_q     <= '0;
      d_hold_q     <= '0;
`ifdef MEM_ARB_RR_EN
      rr_last_q    <= SIDE_F;
`endif
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      f_hold_q     <= f_hold_d;
      d_hold_q     <= d_hold_d;
`ifdef MEM_ARB_RR_EN
      rr_last_q    <= rr_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: memory model, directed sequences, random
// traffic, reference model at the falling edge and a read-data monitor.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [ADDR_W-1:0] f_addr = '0, d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              f_gnt, f_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [DATA_W-1:0] f_rdata, d_rdata, mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        dbg_state;
  logic [3:0]        dbg_starve_cnt;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- memory block ----------------
  logic [DATA_W-1:0] mem     [0:65535];
  logic [DATA_W-1:0] ref_mem [0:65535];

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] f_exp_q[$];
  logic [DATA_W-1:0] d_exp_q[$];
  int                f_due_q[$];
  int                d_due_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: arbitration decided from the request rules, memory kept in
  // program order; expected read data is queued with the cycle it must return.
  int   waits_served;   // data grants given while fetch has been waiting
  logic rr_last_data;   // most recent grant went to the data side
  always @(negedge clock) begin : model
    logic              eg_f, eg_d;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ew;
    eg_f = 1'b0;
    eg_d = 1'b0;
    if (!reset) begin
      waits_served = 0;
      rr_last_data = 1'b0;
      f_exp_q.delete(); f_due_q.delete();
      d_exp_q.delete(); d_due_q.delete();
      check("rst_f_rvalid", 32'(f_rvalid), 32'd0);
      check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
      check("rst_f_rdata",  32'(f_rdata),  32'd0);
      check("rst_d_rdata",  32'(d_rdata),  32'd0);
    end else if (f_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      if (rr_last_data) eg_f = 1'b1;
      else              eg_d = 1'b1;
`else
      if (waits_served >= STARVE_MAX) eg_f = 1'b1;
      else                             eg_d = 1'b1;
`endif
    end else begin
      eg_f = f_req;
      eg_d = d_req;
    end
    ea = eg_f ? f_addr : (eg_d ? d_addr : '0);
    ew = eg_d ? d_wdata : '0;
    check("f_gnt",     32'(f_gnt),     32'(eg_f));
    check("d_gnt",     32'(d_gnt),     32'(eg_d));
    check("mem_en",    32'(mem_en),    32'(eg_f | eg_d));
    check("mem_we",    32'(mem_we),    32'(eg_d & d_we));
    check("mem_addr",  32'(mem_addr),  32'(ea));
    check("mem_wdata", 32'(mem_wdata), 32'(ew));
    if (eg_f) begin
      f_exp_q.push_back(ref_mem[f_addr]);
      f_due_q.push_back(cyc + 1);
    end
    if (eg_d) begin
      if (d_we) begin
        ref_mem[d_addr] = d_wdata;
      end else begin
        d_exp_q.push_back(ref_mem[d_addr]);
        d_due_q.push_back(cyc + 1);
      end
    end
    if (reset) begin
      if (eg_f || !f_req) waits_served = 0;
      else if (eg_d)      waits_served = waits_served + 1;
      if (eg_f)      rr_last_data = 1'b0;
      else if (eg_d) rr_last_data = 1'b1;
    end
  end

  // Monitor: each cycle, rvalid must match whether a read is due now.
  logic [DATA_W-1:0] last_f = '0;
  logic [DATA_W-1:0] last_d = '0;
  always @(posedge clock) begin : monitor
    logic              due;
    logic [DATA_W-1:0] e;
    #2;
    if (!reset) begin
      last_f = '0;
      last_d = '0;
    end else begin
      due = (f_due_q.size() > 0) && (f_due_q[0] == cyc);
      check("f_rvalid", 32'(f_rvalid), 32'(due));
      if (due) begin
        e = f_exp_q.pop_front();
        void'(f_due_q.pop_front());
        check("f_rdata", 32'(f_rdata), 32'(e));
        last_f = e;
      end else begin
        check("f_rdata_hold", 32'(f_rdata), 32'(last_f));
      end
      due = (d_due_q.size() > 0) && (d_due_q[0] == cyc);
      check("d_rvalid", 32'(d_rvalid), 32'(due));
      if (due) begin
        e = d_exp_q.pop_front();
        void'(d_due_q.pop_front());
        check("d_rdata", 32'(d_rdata), 32'(e));
        last_d = e;
      end else begin
        check("d_rdata_hold", 32'(d_rdata), 32'(last_d));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic fr, input logic [ADDR_W-1:0] fa,
                       input logic dr, input logic dw,
                       input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd);
    f_req = fr; f_addr = fa;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    @(posedge clock); #1;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 16'hFFFF;
      1:       return 16'($urandom);
      default: return 16'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic random_phase(input int n, input int pf, input int pd);
    logic fg, dg;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      fg = f_gnt;
      dg = d_gnt;
      @(posedge clock); #1;
      if (fg || !f_req) begin
        f_req  = ($urandom_range(0, 99) < pf);
        f_addr = rand_addr();
      end else if ($urandom_range(0, 19) == 0) begin
        f_req = 1'b0;
      end
      if (dg || !d_req) begin
        d_req   = ($urandom_range(0, 99) < pd);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = rand_addr();
        d_wdata = 16'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        d_req = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'h0010]     = 16'h1234;
    ref_mem[16'h0010] = 16'h1234;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // store then load of the same word
    drive(1'b0, '0, 1'b1, 1'b1, 16'h0001, 16'h000A);
    drive(1'b0, '0, 1'b1, 1'b0, 16'h0001, 16'h0000);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    // single fetch of 0x0010
    drive(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    // both sides held continuously
    for (int i = 0; i < 20; i++) drive(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0002, '0);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    // alternating single-sided loads, one per cycle
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) drive(1'b1, rand_addr(), 1'b0, 1'b0, '0, '0);
      else            drive(1'b0, '0, 1'b1, 1'b0, rand_addr(), '0);
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    // top address and same-address store/fetch contention
    drive(1'b1, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
    drive(1'b1, 16'hFFFF, 1'b0, 1'b0, '0, '0);
    drive(1'b0, '0, 1'b1, 1'b0, 16'hFFFF, '0);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // reset half a cycle into the returning read
    drive(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0);
    f_req = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

    random_phase(800, 90, 90);
    random_phase(800, 50, 50);
    random_phase(800, 20, 80);
    f_req = 1'b0;
    d_req = 1'b0;
    repeat (4) @(posedge clock);
    #3;
    check("drain", 32'(f_exp_q.size() + d_exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
